prbs_gen_chk: RTL and testbench
===============================

# prbs_gen_chk

Parametrised PRBS pattern generator and self-synchronising checker, the successor to the fixed PRBS31 tile. It runs one of four standard polynomials, selected at run time, and emits DATA_W bits per cycle. A matching checker locks onto incoming data and counts bit errors. It sits inside the Tiny Tapeout top wrapper: the generator drives the output pins, and the checker samples the input pins for loopback testing.

## Interface
- DATA_W, 8: bits produced and checked per cycle; legal range 1..31.
- ERR_W, 16: width of the saturating error counter.
- LOCK_CNT, 4: consecutive clean checker words needed to declare lock; must be ≥1.
- UNLOCK_CNT, 4: consecutive errored words in LOCKED needed to drop lock; must be ≥1.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  polynomial select: 00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10 PRBS23 (x^23+x^18+1), 11 PRBS31 (x^31+x^28+1).
- gen_en  in  1  advance the generator by one word this cycle.
- inj_err  in  1  invert the MSB of the word generated this cycle.
- gen_data  out  DATA_W  generated word; the MSB is the earliest bit.
- gen_valid  out  1  gen_data holds a new word.
- chk_valid  in  1  chk_data is a word to check.
- chk_data  in  DATA_W  received word; the MSB is the earliest bit.
- clear  in  1  synchronously zero err_count.
- locked  out  1  checker is in the LOCKED state.
- err_pulse  out  1  the last checked word contained at least one mismatch.
- err_count  out  ERR_W  saturating count of bit mismatches while locked.

## Operation
- **LFSR:** Fibonacci form, 31-bit state s. Only the low N bits are active, where N = 7/15/23/31. Taps for (N, T) are (7,6), (15,14), (23,18), (31,28).
- **Bit step:** new = s[N-1] ^ s[T-1]; s = {s[N-2:0], new}. The output bit is new.
- **Word step:** one word is DATA_W bit steps, unrolled combinationally.
- **Seed:** all ones in the active N bits.
- **Mode change:** mode is registered every cycle. When the registered mode differs from the current input:
  - the generator reloads the seed;
  - the checker returns to HUNT;
  - the lock counter and the unlock counter clear.
  - err_count is kept.
- **Generator:**
  - When gen_en is high, the LFSR advances one word and gen_data is registered.
  - When gen_en is low, gen_data and the LFSR hold.
  - inj_err inverts gen_data[DATA_W-1] only; it never affects the LFSR state.
- **Checker states:** HUNT and LOCKED. The checker acts only on cycles where chk_valid is high; otherwise it holds.
- **HUNT:**
  - Each received bit is predicted from the previous N received bits, using the same tap rule.
  - The received bits are then shifted into the checker LFSR (self-synchronising).
  - A word with zero mismatches increments lock_ctr. Any mismatch clears lock_ctr.
  - When lock_ctr reaches LOCK_CNT: go to LOCKED and clear lock_ctr.
  - err_count is not incremented in HUNT. err_pulse still reports mismatches.
- **LOCKED:**
  - The checker LFSR free-runs on its own predicted bits; received data is not loaded.
  - Each word's mismatch popcount is added to err_count.
  - A word with any mismatch increments unlock_ctr. A clean word clears unlock_ctr.
  - When unlock_ctr reaches UNLOCK_CNT: go to HUNT and clear unlock_ctr.
- **err_count:**
  - Saturates at 2^ERR_W-1; it never wraps.
  - When clear and an increment occur in the same cycle, clear wins and err_count = 0.

## Timing
- **Reset values:**
  - gen_data = 0, gen_valid = 0;
  - locked = 0, err_pulse = 0, err_count = 0;
  - checker state = HUNT, both counters = 0;
  - generator LFSR = seed for the mode present at reset.
- **Generator latency:** 1 cycle. gen_en high at edge k gives gen_data and gen_valid = 1 after edge k. gen_valid is low for any cycle with gen_en low.
- **Checker latency:** err_pulse and the err_count update are registered, and appear 1 cycle after the chk_valid word.
- **Lock timing:** locked rises in the cycle after the LOCK_CNT-th clean word. It falls in the cycle after the UNLOCK_CNT-th errored word.
- **Mode change:** takes effect on the first cycle after the change. A gen_en in that cycle produces the first word from the seed.
- **Reset mid-operation:** reset is asynchronous and immediately forces all reset values. The first word after release starts from the seed.
- **Throughput:** one word per cycle on both sides. There is no backpressure.

## Test plan
- **Reset and seed:** release reset, mode=00, DATA_W=8, gen_en=1 for two cycles -> gen_data = 8'h02, then 8'h0C; gen_valid = 1 on both words.
- **Loopback lock:** mode=11, chk_data = gen_data delayed one cycle, chk_valid = gen_valid -> locked rises after 4 clean words; err_count stays 0 for 10000 words.
- **Error injection:** while locked, pulse inj_err on 3 separate words -> err_pulse high on exactly 3 cycles; err_count = 3 (one bit each, the bit is not self-synchronised); locked stays 1.
- **Loss of lock:** while locked, invert all chk_data bits for 4 words -> err_count += 32; locked falls; restoring clean data relocks after 4 clean words.
- **Saturation and clear:** ERR_W=4, inject 20 errors while locked -> err_count = 15 and holds; assert clear in the same cycle as an error -> err_count = 0.
- **Mode switch and reset mid-stream:** change mode 11 -> 00 mid-stream -> locked = 0 next cycle; the next generated word is 8'h02. Assert rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: run-time selectable PRBS7/15/23/31 word generator
// plus a self-synchronising checker with a saturating error counter.
module prbs_gen_chk #(
    parameter int DATA_W     = 8,
    parameter int ERR_W      = 16,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              gen_en,
    input  logic              inj_err,
    output logic [DATA_W-1:0] gen_data,
    output logic              gen_valid,
    input  logic              chk_valid,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count
);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam int SW = ERR_W + 6;
    localparam logic [30:0] SEED = 31'h7FFF_FFFF;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    // feedback bit for the selected polynomial
    function automatic logic f_tap(input logic [30:0] s, input logic [1:0] m);
        logic b;
        case (m)
            2'b00:   b = s[6] ^ s[5];
            2'b01:   b = s[14] ^ s[13];
            2'b10:   b = s[22] ^ s[17];
            default: b = s[30] ^ s[27];
        endcase
        return b;
    endfunction

    logic [1:0]        r_mode;
    logic              r_mode_vld;
    logic              w_mode_chg;
    logic [30:0]       r_gen_lfsr;
    logic [30:0]       w_gen_s;
    logic [DATA_W-1:0] w_gen_word;
    logic [DATA_W-1:0] w_inj_mask;
    logic [DATA_W-1:0] r_gen_data;
    logic              r_gen_valid;

    logic [30:0]       r_chk_lfsr;
    logic [30:0]       w_cp;
    logic [30:0]       w_cr;
    logic              w_pl;
    logic              w_ph;
    logic [DATA_W-1:0] w_mis;
    logic [5:0]        w_pop;
    logic [SW-1:0]     w_sum;
    logic [ERR_W-1:0]  w_err_sat;

    state_t            r_state;
    state_t            w_state_nx;
    logic [LW-1:0]     r_lock_ctr;
    logic [LW-1:0]     w_lock_nx;
    logic [UW-1:0]     r_unlock_ctr;
    logic [UW-1:0]     w_unlock_nx;
    logic              r_err_pulse;
    logic              w_err_pulse_nx;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [ERR_W-1:0]  w_err_cnt_nx;
    logic [30:0]       w_chk_lfsr_nx;

    // first sample after reset only establishes the reference mode
    assign w_mode_chg = r_mode_vld && (r_mode != mode);
    assign w_inj_mask = DATA_W'(inj_err) << (DATA_W - 1);

    // unrolled generator word, MSB is the earliest bit
    always_comb begin
        w_gen_s    = w_mode_chg ? SEED : r_gen_lfsr;
        w_gen_word = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_gen_word[i] = f_tap(w_gen_s, mode);
            w_gen_s       = {w_gen_s[29:0], w_gen_word[i]};
        end
    end

    // generator state, output word and mode tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 2'b00;
            r_mode_vld  <= 1'b0;
            r_gen_lfsr  <= SEED;
            r_gen_data  <= '0;
            r_gen_valid <= 1'b0;
        end else begin
            r_mode      <= mode;
            r_mode_vld  <= 1'b1;
            r_gen_valid <= gen_en;
            if (gen_en) begin
                r_gen_lfsr <= w_gen_s;
                r_gen_data <= w_gen_word ^ w_inj_mask;
            end else if (w_mode_chg) begin
                r_gen_lfsr <= SEED;
            end
        end
    end

    // per-bit prediction: free-running (locked) and self-sync (hunt)
    always_comb begin
        w_cp  = r_chk_lfsr;
        w_cr  = r_chk_lfsr;
        w_pl  = 1'b0;
        w_ph  = 1'b0;
        w_mis = '0;
        w_pop = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_pl     = f_tap(w_cp, mode);
            w_ph     = f_tap(w_cr, mode);
            w_mis[i] = chk_data[i] ^ ((r_state == S_LOCKED) ? w_pl : w_ph);
            w_cp     = {w_cp[29:0], w_pl};
            w_cr     = {w_cr[29:0], chk_data[i]};
            w_pop    = w_pop + 6'(w_mis[i]);
        end
    end

    assign w_sum     = SW'(r_err_cnt) + SW'(w_pop);
    assign w_err_sat = (w_sum > SW'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];

    // hunt/locked next-state, counters and error accounting
    always_comb begin
        w_state_nx     = r_state;
        w_lock_nx      = r_lock_ctr;
        w_unlock_nx    = r_unlock_ctr;
        w_err_pulse_nx = 1'b0;
        w_err_cnt_nx   = r_err_cnt;
        w_chk_lfsr_nx  = r_chk_lfsr;
        if (w_mode_chg) begin
            w_state_nx  = S_HUNT;
            w_lock_nx   = '0;
            w_unlock_nx = '0;
        end else if (chk_valid) begin
            w_err_pulse_nx = |w_mis;
            unique case (r_state)
                S_HUNT: begin
                    w_chk_lfsr_nx = w_cr;
                    if (|w_mis) begin
                        w_lock_nx = '0;
                    end else if (r_lock_ctr == LW'(LOCK_CNT - 1)) begin
                        w_state_nx = S_LOCKED;
                        w_lock_nx  = '0;
                    end else begin
                        w_lock_nx = r_lock_ctr + 1'b1;
                    end
                end
                S_LOCKED: begin
                    w_chk_lfsr_nx = w_cp;
                    w_err_cnt_nx  = w_err_sat;
                    if (!(|w_mis)) begin
                        w_unlock_nx = '0;
                    end else if (r_unlock_ctr == UW'(UNLOCK_CNT - 1)) begin
                        w_state_nx  = S_HUNT;
                        w_unlock_nx = '0;
                    end else begin
                        w_unlock_nx = r_unlock_ctr + 1'b1;
                    end
                end
            endcase
        end
        if (clear) begin
            w_err_cnt_nx = '0;
        end
    end

    // checker state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_HUNT;
            r_lock_ctr   <= '0;
            r_unlock_ctr <= '0;
            r_err_pulse  <= 1'b0;
            r_err_cnt    <= '0;
            r_chk_lfsr   <= SEED;
        end else begin
            r_state      <= w_state_nx;
            r_lock_ctr   <= w_lock_nx;
            r_unlock_ctr <= w_unlock_nx;
            r_err_pulse  <= w_err_pulse_nx;
            r_err_cnt    <= w_err_cnt_nx;
            r_chk_lfsr   <= w_chk_lfsr_nx;
        end
    end

    assign gen_data  = r_gen_data;
    assign gen_valid = r_gen_valid;
    assign locked    = (r_state == S_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: table vectors, loopback sequences and random
// stimulus against a bit-recurrence reference model.
module tb_prbs_gen_chk;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] t_mode = 2'b00;
    logic       t_gen_en = 1'b0;
    logic       t_inj = 1'b0;
    logic       t_chk_valid = 1'b0;
    logic [7:0] t_chk_data = 8'h00;
    logic       t_clear = 1'b0;

    logic [7:0]  gen_data, s_gen_data;
    logic        gen_valid, s_gen_valid;
    logic        locked, s_locked;
    logic        err_pulse, s_err_pulse;
    logic [15:0] err_count;
    logic [3:0]  s_err_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prbs_gen_chk #(.DATA_W(8), .ERR_W(16), .LOCK_CNT(4), .UNLOCK_CNT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(t_mode), .gen_en(t_gen_en),
        .inj_err(t_inj), .gen_data(gen_data), .gen_valid(gen_valid),
        .chk_valid(t_chk_valid), .chk_data(t_chk_data), .clear(t_clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs_gen_chk #(.DATA_W(8), .ERR_W(4), .LOCK_CNT(4), .UNLOCK_CNT(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .mode(t_mode), .gen_en(t_gen_en),
        .inj_err(t_inj), .gen_data(s_gen_data), .gen_valid(s_gen_valid),
        .chk_valid(t_chk_valid), .chk_data(t_chk_data), .clear(t_clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count)
    );

    // reference model: bit histories, oldest first, newest last
    bit         gq[$];
    bit         cq[$];
    int         m_prev_mode;
    bit         m_locked;
    int         m_good, m_bad, m_total;
    logic [7:0] m_gdata;
    bit         m_gvalid, m_pulse;

    task automatic taps(input logic [1:0] m, output int n, output int t);
        case (m)
            2'b00:   begin n = 7;  t = 6;  end
            2'b01:   begin n = 15; t = 14; end
            2'b10:   begin n = 23; t = 18; end
            default: begin n = 31; t = 28; end
        endcase
    endtask

    task automatic model_reset();
        gq.delete();
        cq.delete();
        for (int i = 0; i < 31; i++) begin
            gq.push_back(1'b1);
            cq.push_back(1'b1);
        end
        m_prev_mode = -1;
        m_locked = 0; m_good = 0; m_bad = 0; m_total = 0;
        m_gdata = 8'h00; m_gvalid = 0; m_pulse = 0;
    endtask

    task automatic model_edge();
        bit chg, b, rx, pred;
        int n, t, pop;
        logic [7:0] w;
        chg = (m_prev_mode >= 0) && (m_prev_mode != int'(t_mode));
        taps(t_mode, n, t);
        if (chg) begin
            gq.delete();
            for (int i = 0; i < 31; i++) gq.push_back(1'b1);
        end
        if (t_gen_en) begin
            w = 8'h00;
            for (int i = 0; i < 8; i++) begin
                b = gq[gq.size() - n] ^ gq[gq.size() - t];
                gq.push_back(b);
                void'(gq.pop_front());
                w = {w[6:0], b};
            end
            m_gdata  = w ^ (t_inj ? 8'h80 : 8'h00);
            m_gvalid = 1;
        end else begin
            m_gvalid = 0;
        end
        m_pulse = 0;
        if (chg) begin
            m_locked = 0; m_good = 0; m_bad = 0;
        end else if (t_chk_valid) begin
            pop = 0;
            for (int i = 0; i < 8; i++) begin
                rx   = t_chk_data[7 - i];
                pred = cq[cq.size() - n] ^ cq[cq.size() - t];
                if (pred != rx) pop++;
                cq.push_back(m_locked ? pred : rx);
                void'(cq.pop_front());
            end
            m_pulse = (pop > 0);
            if (m_locked) begin
                m_total += pop;
                if (pop > 0) begin
                    m_bad++;
                    if (m_bad == 4) begin m_locked = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end else if (pop == 0) begin
                m_good++;
                if (m_good == 4) begin m_locked = 1; m_good = 0; end
            end else begin
                m_good = 0;
            end
        end
        if (t_clear) m_total = 0;
        m_prev_mode = int'(t_mode);
    endtask

    function automatic int satv(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("gen_data", 32'(gen_data), 32'(m_gdata));
        cmp("gen_valid", 32'(gen_valid), 32'(m_gvalid));
        cmp("locked", 32'(locked), 32'(m_locked));
        cmp("err_pulse", 32'(err_pulse), 32'(m_pulse));
        cmp("err_count", 32'(err_count), 32'(satv(m_total, 16)));
        cmp("err_count_sat", 32'(s_err_count), 32'(satv(m_total, 4)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // asynchronous reset: outputs must clear without a clock edge
    task automatic do_reset(input logic [1:0] m);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_gen_data", 32'(gen_data), 32'h0);
        cmp("rst_gen_valid", 32'(gen_valid), 32'h0);
        cmp("rst_locked", 32'(locked), 32'h0);
        cmp("rst_err_pulse", 32'(err_pulse), 32'h0);
        cmp("rst_err_count", 32'(err_count), 32'h0);
        cmp("rst_err_count_sat", 32'(s_err_count), 32'h0);
        model_reset();
        t_mode = m; t_gen_en = 0; t_inj = 0;
        t_chk_valid = 0; t_chk_data = 8'h00; t_clear = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // loopback word: checker sees the previous generated word
    task automatic lb(input logic inj, input logic [7:0] mask, input logic clr);
        t_gen_en = 1; t_inj = inj; t_clear = clr;
        t_chk_valid = m_gvalid;
        t_chk_data = m_gdata ^ mask;
        tick();
        t_inj = 0; t_clear = 0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic       inj;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t tbl[7];
    int   pulses;

    initial begin
        tbl[0] = '{2'b00, 1'b1, 1'b0, 8'h02, 1'b1};
        tbl[1] = '{2'b00, 1'b1, 1'b0, 8'h0C, 1'b1};
        tbl[2] = '{2'b00, 1'b0, 1'b0, 8'h0C, 1'b0};
        tbl[3] = '{2'b00, 1'b1, 1'b1, 8'hA8, 1'b1};
        tbl[4] = '{2'b00, 1'b1, 1'b0, 8'hF2, 1'b1};
        tbl[5] = '{2'b01, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{2'b01, 1'b1, 1'b0, 8'h02, 1'b1};

        do_reset(2'b00);
        for (int i = 0; i < 7; i++) begin
            t_mode = tbl[i].mode;
            t_gen_en = tbl[i].en;
            t_inj = tbl[i].inj;
            t_chk_valid = 0;
            tick();
            cmp("tbl_data", 32'(gen_data), 32'(tbl[i].exp_data));
            cmp("tbl_valid", 32'(gen_valid), 32'(tbl[i].exp_valid));
        end
        t_inj = 0;

        do_reset(2'b11);
        for (int i = 1; i <= 10004; i++) begin
            lb(0, 8'h00, 0);
            if (i == 4) cmp("lock_early", 32'(locked), 32'h0);
            if (i == 5) cmp("lock_rise", 32'(locked), 32'h1);
        end
        cmp("loop_clean", 32'(err_count), 32'h0);

        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            lb((i == 3) || (i == 10) || (i == 20), 8'h00, 0);
            if (err_pulse === 1'b1) pulses++;
        end
        cmp("inj_pulses", 32'(pulses), 32'd3);
        cmp("inj_count", 32'(err_count), 32'd3);
        cmp("inj_locked", 32'(locked), 32'h1);

        for (int i = 0; i < 4; i++) lb(0, 8'hFF, 0);
        cmp("unlock_fall", 32'(locked), 32'h0);
        cmp("unlock_count", 32'(err_count), 32'd35);
        cmp("unlock_sat", 32'(s_err_count), 32'd15);
        for (int i = 1; i <= 4; i++) begin
            lb(0, 8'h00, 0);
            if (i == 3) cmp("relock_early", 32'(locked), 32'h0);
            if (i == 4) cmp("relock_rise", 32'(locked), 32'h1);
        end

        lb(0, 8'h00, 1);
        cmp("clear_main", 32'(err_count), 32'h0);
        for (int i = 0; i < 40; i++) lb(i % 2 == 0, 8'h00, 0);
        cmp("sat_hold", 32'(s_err_count), 32'd15);
        cmp("sat_main", 32'(err_count), 32'd20);
        cmp("sat_locked", 32'(locked), 32'h1);
        lb(1, 8'h00, 0);
        lb(0, 8'h00, 1);
        cmp("clr_win_main", 32'(err_count), 32'h0);
        cmp("clr_win_sat", 32'(s_err_count), 32'h0);
        cmp("clr_win_pulse", 32'(err_pulse), 32'h1);
        for (int i = 0; i < 5; i++) lb(0, 8'h00, 0);

        t_mode = 2'b00;
        lb(0, 8'h00, 0);
        cmp("mchg_locked", 32'(locked), 32'h0);
        cmp("mchg_seed", 32'(gen_data), 32'h02);
        for (int i = 0; i < 40; i++) lb(0, 8'h00, 0);
        cmp("mchg_relock", 32'(locked), 32'h1);

        do_reset(2'b10);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) t_mode = 2'($urandom_range(0, 3));
            t_gen_en = ($urandom_range(0, 99) < 85);
            t_inj = ($urandom_range(0, 99) < 3);
            t_clear = ($urandom_range(0, 99) < 1);
            t_chk_valid = m_gvalid && ($urandom_range(0, 9) != 0);
            t_chk_data = m_gdata ^ (($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
